sha2_core_probe: RTL and testbench

SHA2_CORE_PROBE -- requirements
Module: sha2_core_probe

---
 rtl/sha2_pkg.sv | 74 +++++++
 rtl/sha2_round.sv | 23 ++
 rtl/sha2_core_probe.sv | 125 ++++++++++++
 tb/tb_sha2_core_probe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// SHA-256 shared definitions: round constants, IV, FSM states and
// the FIPS 180-4 logical functions used by the core and round datapath.
package sha2_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROUND  = 2'd1,
    S_UPDATE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Eight 32-bit words: index 0 is a / H0, index 7 is h / H7.
  typedef logic [0:7][31:0] wv_t;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam wv_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(
    input logic [31:0] x,
    input int unsigned n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(
    input logic [31:0] x, y, z
  );
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(
    input logic [31:0] x, y, z
  );
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha2_round.sv
// One SHA-256 compression round.
// Ports: v_i = a..h in, k_i = K_t, w_i = W_t, v_o = next a..h.
module sha2_round
  import sha2_pkg::*;
(
  input  wv_t         v_i,
  input  logic [31:0] k_i,
  input  logic [31:0] w_i,
  output wv_t         v_o
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1 = v_i[7] + bsig1(v_i[4]) + ch(v_i[4], v_i[5], v_i[6])
       + k_i + w_i;
    t2 = bsig0(v_i[0]) + maj(v_i[0], v_i[1], v_i[2]);
    v_o = {t1 + t2, v_i[0], v_i[1], v_i[2],
           v_i[3] + t1, v_i[4], v_i[5], v_i[6]};
  end

endmodule

// File: rtl/sha2_core_probe.sv
// SHA-256 block compression core, one round per clock, chained H state.
// Ports: clk, rst (sync active-low), load/start/data_in in; end_op,
// H_out (H0 in MSBs) out; probe1..4 = a, e, W_t, t when SHA2_PROBE_EN
// is defined, otherwise tied to zero.
module sha2_core_probe
  import sha2_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         start,
  input  logic [31:0]  data_in,
  output logic         end_op,
  output logic [255:0] H_out,
  output logic [31:0]  probe1,
  output logic [31:0]  probe2,
  output logic [31:0]  probe3,
  output logic [31:0]  probe4
);

  state_e state_q, state_d;
  logic [6:0] t_q, t_d;
  logic end_op_q, end_op_d;
  wv_t h_q, h_d;
  wv_t v_q, v_d;
  wv_t v_rnd;
  // blk holds the loaded block; w is the live schedule window, w[0] = W_t.
  logic [0:15][31:0] blk_q, blk_d;
  logic [0:15][31:0] w_q, w_d;
  logic [31:0] w_new;

  sha2_round u_round (
    .v_i (v_q),
    .k_i (K[t_q[5:0]]),
    .w_i (w_q[0]),
    .v_o (v_rnd)
  );

  // Produces W_{t+16} from the window holding W_t..W_{t+15}.
  assign w_new = ssig1(w_q[14]) + w_q[9]
               + ssig0(w_q[1]) + w_q[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      end_op_q <= 1'b0;
      h_q      <= IV;
      v_q      <= '0;
      blk_q    <= '0;
      w_q      <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      end_op_q <= end_op_d;
      h_q      <= h_d;
      v_q      <= v_d;
      blk_q    <= blk_d;
      w_q      <= w_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_ROUND;
      S_ROUND: if (t_q == 7'd63) state_d = S_UPDATE;
      S_UPDATE: state_d = S_DONE;
      S_DONE: begin
        if (start) state_d = S_ROUND;
        else if (load) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    t_d      = t_q;
    end_op_d = end_op_q;
    h_d      = h_q;
    v_d      = v_q;
    blk_d    = blk_q;
    w_d      = w_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          v_d      = h_q;
          t_d      = '0;
          end_op_d = 1'b0;
          w_d      = blk_q;
        end else if (load) begin
          blk_d    = {blk_q[1:15], data_in};
          end_op_d = 1'b0;
        end else if (state_q == S_DONE) begin
          end_op_d = 1'b1;
        end
      end
      S_ROUND: begin
        v_d = v_rnd;
        t_d = t_q + 7'd1;
        w_d = {w_q[1:15], w_new};
      end
      S_UPDATE: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
      end
      default: ;
    endcase
  end

  assign end_op = end_op_q;
  assign H_out  = h_q;

`ifdef SHA2_PROBE_EN
  assign probe1 = v_q[0];
  assign probe2 = v_q[4];
  assign probe3 = w_q[0];
  assign probe4 = {25'd0, t_q};
`else
  assign probe1 = '0;
  assign probe2 = '0;
  assign probe3 = '0;
  assign probe4 = '0;
`endif

endmodule

// File: tb/tb_sha2_core_probe.sv
// Self-checking bench for sha2_core_probe: known SHA-256 vectors plus
// randomized chained blocks against a behavioural SHA-256 model.
module tb_sha2_core_probe;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  data_in = '0;
  logic         end_op;
  logic [255:0] H_out;
  logic [31:0]  probe1, probe2, probe3, probe4;

  sha2_core_probe dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .start   (start),
    .data_in (data_in),
    .end_op  (end_op),
    .H_out   (H_out),
    .probe1  (probe1),
    .probe2  (probe2),
    .probe3  (probe3),
    .probe4  (probe4)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  logic [31:0] kt [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] iv [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic [31:0] mh [8];
  logic [31:0] mbuf [16];

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] iv_pack();
    return {iv[0], iv[1], iv[2], iv[3], iv[4], iv[5], iv[6], iv[7]};
  endfunction

  function automatic logic [255:0] mh_pack();
    return {mh[0], mh[1], mh[2], mh[3], mh[4], mh[5], mh[6], mh[7]};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) mh[i] = iv[i];
    for (int i = 0; i < 16; i++) mbuf[i] = '0;
  endtask

  task automatic m_load(input logic [31:0] w);
    for (int i = 0; i < 15; i++) mbuf[i] = mbuf[i+1];
    mbuf[15] = w;
  endtask

  // Textbook FIPS 180-4 compression with a full 64-entry schedule.
  task automatic m_compress();
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = mbuf[i];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = mh[i];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[i] + w[i];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) mh[i] = mh[i] + v[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] w);
    load = 1'b1;
    data_in = w;
    tick();
    load = 1'b0;
    m_load(w);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    load = 1'b1;
    start = 1'b1;
    data_in = $urandom;
    repeat (n) tick();
    rst = 1'b1;
    load = 1'b0;
    start = 1'b0;
    m_reset();
  endtask

  // Starts a block and checks end_op timing and the digest.
  // inj: tick index at which start+load are pulsed while busy (0 = none).
  // with_load: also hold load high on the start edge.
  task automatic do_block(input string tag, input int inj,
                          input bit prb, input bit with_load);
    start = 1'b1;
    load = with_load;
    data_in = $urandom;
    tick();
    start = 1'b0;
    load = 1'b0;
`ifdef SHA2_PROBE_EN
    if (prb) begin
      chk("probe3_w0", {224'd0, probe3}, {224'd0, mbuf[0]});
      chk("probe4_t0", {224'd0, probe4}, 256'd0);
    end
`endif
    for (int i = 1; i <= 65; i++) begin
      if (i == inj) begin
        start = 1'b1;
        load = 1'b1;
        data_in = $urandom;
      end
      tick();
      start = 1'b0;
      load = 1'b0;
      if (prb && i == 1) begin
`ifdef SHA2_PROBE_EN
        chk("probe1_a", {224'd0, probe1}, {224'd0, 32'h5d6aebcd});
        chk("probe2_e", {224'd0, probe2}, {224'd0, 32'hfa2a4622});
        chk("probe4_t1", {224'd0, probe4}, 256'd1);
`else
        chk("probes_off", {128'd0, probe1, probe2, probe3, probe4},
            256'd0);
`endif
      end
    end
    chk({tag, "_eop_early"}, {255'd0, end_op}, 256'd0);
    tick();
    chk({tag, "_eop"}, {255'd0, end_op}, 256'd1);
    m_compress();
    chk({tag, "_h"}, H_out, mh_pack());
  endtask

  task automatic load_abc();
    do_load(32'h61626380);
    for (int i = 0; i < 14; i++) do_load(32'h0);
    do_load(32'h00000018);
  endtask

  logic [31:0] blk1 [16] = '{
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };

  initial begin
    m_reset();
    // Reset state
    do_reset(10);
    chk("rst_eop", {255'd0, end_op}, 256'd0);
    chk("rst_h", H_out, iv_pack());

    // "abc" single block, with probe checks
    load_abc();
    do_block("abc", 0, 1'b1, 1'b0);
    chk("abc_dig", H_out, ABC_DIG);

    // Load in DONE clears end_op
    do_load(32'h12345678);
    chk("load_clr_eop", {255'd0, end_op}, 256'd0);

    // Two-block message from IV
    do_reset(1);
    for (int i = 0; i < 16; i++) do_load(blk1[i]);
    do_block("blk1", 0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) do_load(32'h0);
    do_load(32'h000001c0);
    do_block("blk2", 0, 1'b0, 1'b0);
    chk("two_dig", H_out, TWO_DIG);

    // Busy robustness: start+load pulsed at round 10
    do_reset(1);
    load_abc();
    do_block("busy", 11, 1'b0, 1'b0);
    chk("busy_dig", H_out, ABC_DIG);

    // Reset aborts mid-operation at round 30
    load_abc();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    do_reset(1);
    chk("abort_h", H_out, iv_pack());
    chk("abort_eop", {255'd0, end_op}, 256'd0);
    repeat (70) tick();
    chk("abort_idle_eop", {255'd0, end_op}, 256'd0);
    load_abc();
    do_block("after_abort", 0, 1'b0, 1'b0);
    chk("after_abort_dig", H_out, ABC_DIG);

    // Randomized chained blocks: over-length loads, start+load together,
    // and partial reloads that keep older buffer words.
    for (int b = 0; b < 5; b++) begin
      int n;
      n = (b % 2 == 0) ? 16 + int'($urandom_range(0, 6))
                       : int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) do_load($urandom);
      do_block("rand", (b == 3) ? int'($urandom_range(2, 64)) : 0,
               1'b0, b[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
